fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core (delayed-branch semantics, one delay slot).
- Owns the PC and drives the instruction-memory address.
- Computes next PC from redirect requests issued by the decode stage.
- Presents D_instr/D_pc to the decoder and the comparator/hazard logic in the decode stage.

Parameters:
- PC_INIT, 32'h0000_3000, PC value after reset.
- PC_MIN, 32'h0000_3000, lowest legal fetch address (inclusive).
- PC_MAX, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  from hazard unit; holds PC and IF/ID.
- flush  in  1  clears IF/ID to a bubble; reserved for exception handling.
- imem_addr  out  32  current fetch PC (F_pc).
- imem_rdata  in  32  instruction word; combinational return for imem_addr.
- branch_en  in  1  decode-stage instruction is a conditional branch (Branch != BRANCH_DISABLE).
- branch_taken  in  1  comparator result for D_instr.
- jump  in  JUMP_SIZE  decode-stage jump kind: JUMP_DISABLE, JUMP_INDEX or JUMP_REG.
- rs_fwd  in  32  forwarded rs value of D_instr, for jr.
- D_instr  out  32  IF/ID instruction.
- D_pc  out  32  IF/ID PC.
- D_pc8  out  32  D_pc + 8, the link value.
- D_adel  out  1  IF/ID fetch-address-error flag.

Behaviour:
- Reset (async): F_pc=PC_INIT; D_instr=0; D_pc=PC_INIT; D_adel=0. Outputs take these values while reset is high.
- Fetch is combinational, with zero-cycle latency from imem_addr to imem_rdata.
- F_adel = (F_pc[1:0]!=0) | (F_pc<PC_MIN) | (F_pc>PC_MAX).
- Next PC is computed from the D-stage instruction in priority order:
  - jump==JUMP_REG: rs_fwd.
  - jump==JUMP_INDEX: {D_pc4[31:28], D_instr[25:0], 2'b00}, where D_pc4=D_pc+4.
  - branch_en & branch_taken: D_pc4 + (sext(D_instr[15:0])<<2).
  - otherwise: F_pc+4.
- All address arithmetic is 32-bit modulo 2^32; wrap at 32'hFFFF_FFFC is silent, and the result is then flagged through F_adel.
- Delay slot: the redirect does not squash the instruction currently in F. That instruction enters IF/ID normally in the same edge that loads the target into F_pc.
- Edge priority is reset > flush > stall > normal.
  - normal: F_pc <= next PC; D_instr <= F_adel ? 0 : imem_rdata; D_pc <= F_pc; D_adel <= F_adel.
  - stall: F_pc, D_instr, D_pc, D_adel all hold. Any redirect is ignored this cycle; it is re-evaluated when stall deasserts, because D_instr is unchanged.
  - flush (overrides stall): D_instr <= 0; D_adel <= 0; D_pc <= F_pc. F_pc <= next PC if stall=0, else holds.
- Misaligned jr target (e.g. rs_fwd=32'h3001): F_pc takes the value unchanged; the word fetched there is replaced by 0 in IF/ID and D_adel=1.
- D_pc8 = D_pc + 8, combinational from the register.
- No internal state besides F_pc and the IF/ID register; there is no FSM beyond stall/flush control.

Decomposition:
- macros.v (shared):
  - existing JUMP_* and BRANCH_* encodings.
  - new PC_INIT / PC_MIN / PC_MAX defaults.
  - NOP constant (32'h0).
- Sub-module next_pc: purely combinational selection of the next PC from F_pc, D_pc, D_instr, branch_en, branch_taken, jump and rs_fwd.
- fetch_stage holds the registers and the stall/flush priority.

Test Plan:
- Reset release with imem returning 32'h3402_0005 (ori) -> imem_addr=3000, then 3004, 3008. D_pc lags by one cycle (3000 at the second edge) and D_instr=3402_0005.
- Taken beq at D_pc=300C with imm=16'hFFFD (branch_en=1, taken=1) -> delay slot 3010 enters IF/ID. Next imem_addr=3004 (300C+4-12). Repeat with taken=0 -> imem_addr=3014.
- jal at D_pc=3000 with index=26'h0000C10 (jump=JUMP_INDEX) -> next imem_addr=3040, D_pc8=3008. jr with rs_fwd=32'h0000_3100 -> next imem_addr=3100.
- stall held for 2 cycles while a taken beq sits in D -> F_pc, D_instr and D_pc unchanged for both cycles. On the first non-stall edge F_pc becomes the branch target and the delay slot is latched once.
- flush and stall together -> D_instr=0, D_adel=0, F_pc unchanged. flush alone -> D_instr=0 and F_pc advances.
- jr to 32'h3002, then jr to 32'h7000 -> D_adel=1 and D_instr=0 in both cases. Assert reset mid-cycle with F_pc=3020 -> F_pc=3000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared encodings and address-map defaults for the fetch stage
package fetch_stage_pkg;
  localparam int JUMP_SIZE = 2;
  typedef enum logic [JUMP_SIZE-1:0] {JUMP_DISABLE, JUMP_INDEX, JUMP_REG} jump_e;
  typedef enum logic [1:0] {BRANCH_DISABLE, BRANCH_BEQ, BRANCH_BNE} branch_e;
  localparam logic [31:0] PC_INIT_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_MIN_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_MAX_DEFAULT = 32'h0000_6FFC;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory fetch bus (combinational read)
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  modport master(output imem_addr, input imem_rdata);
  modport slave(input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_next_pc.sv
// next_pc: combinational next-PC selection from the decode-stage redirect
module next_pc
  import fetch_stage_pkg::*;
(
  input  logic [31:0]          f_pc_i,
  input  logic [31:0]          d_pc_i,
  input  logic [25:0]          d_idx_i,
  input  logic                 branch_en_i,
  input  logic                 branch_taken_i,
  input  logic [JUMP_SIZE-1:0] jump_i,
  input  logic [31:0]          rs_fwd_i,
  output logic [31:0]          npc_o
);
  logic [31:0] d_pc4;
  logic [31:0] br_off;
  assign d_pc4 = d_pc_i + 32'd4;
  assign br_off = {{14{d_idx_i[15]}}, d_idx_i[15:0], 2'b00};
  // jr beats j/jal beats a taken branch; otherwise fall through sequentially
  always_comb npc_o = (jump_i == JUMP_REG) ? rs_fwd_i :
                      (jump_i == JUMP_INDEX) ? {d_pc4[31:28], d_idx_i, 2'b00} :
                      (branch_en_i & branch_taken_i) ? d_pc4 + br_off :
                      f_pc_i + 32'd4;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT,
  parameter logic [31:0] PC_MIN  = PC_MIN_DEFAULT,
  parameter logic [31:0] PC_MAX  = PC_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  fetch_stage_if.master        imem,
  input  logic                 branch_en,
  input  logic                 branch_taken,
  input  logic [JUMP_SIZE-1:0] jump,
  input  logic [31:0]          rs_fwd,
  output logic [31:0]          D_instr,
  output logic [31:0]          D_pc,
  output logic [31:0]          D_pc8,
  output logic                 D_adel
);
  logic [31:0] f_pc_q, f_pc_d, d_instr_q, d_instr_d, d_pc_q, d_pc_d, npc;
  logic        d_adel_q, d_adel_d, f_adel;
  next_pc u_next_pc (
    .f_pc_i(f_pc_q),
    .d_pc_i(d_pc_q),
    .d_idx_i(d_instr_q[25:0]),
    .branch_en_i(branch_en),
    .branch_taken_i(branch_taken),
    .jump_i(jump),
    .rs_fwd_i(rs_fwd),
    .npc_o(npc)
  );
  assign f_adel = (|f_pc_q[1:0]) | (f_pc_q < PC_MIN) | (f_pc_q > PC_MAX);
  // flush bubbles IF/ID but still lets the PC advance unless stalled; a bad fetch enters as NOP
  always_comb begin
    f_pc_d    = stall ? f_pc_q : npc;
    d_instr_d = flush ? NOP : stall ? d_instr_q : f_adel ? NOP : imem.imem_rdata;
    d_pc_d    = (flush | ~stall) ? f_pc_q : d_pc_q;
    d_adel_d  = flush ? 1'b0 : stall ? d_adel_q : f_adel;
  end
  // PC and IF/ID state, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q    <= PC_INIT;
      d_instr_q <= NOP;
      d_pc_q    <= PC_INIT;
      d_adel_q  <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_adel_q  <= d_adel_d;
    end
  end
  assign imem.imem_addr = f_pc_q;
  assign D_instr = d_instr_q;
  assign D_pc    = d_pc_q;
  assign D_adel  = d_adel_q;
  assign D_pc8   = d_pc_q + 32'd8;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, corner sequences and randomized model check of fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  typedef struct {
    logic        st, fl, be, bt;
    logic [1:0]  jp;
    logic [31:0] rs, rd, e_addr, e_instr, e_pc;
    logic        e_adel;
  } vec_t;
  localparam logic [1:0] JD = JUMP_DISABLE;
  localparam logic [1:0] JI = JUMP_INDEX;
  localparam logic [1:0] JR = JUMP_REG;
  localparam logic [31:0] ORI = 32'h3402_0005;
  localparam logic [31:0] BEQ = 32'h1000_FFFD;
  localparam logic [31:0] JAL = 32'h0C00_0C10;
  logic clk = 0, reset = 0, stall = 0, flush = 0, branch_en = 0, branch_taken = 0;
  logic [1:0] jump = 0;
  logic [31:0] rs_fwd = 0, D_instr, D_pc, D_pc8, ovr_word = 0;
  logic D_adel, ovr = 0;
  int n_pass = 0, n_tot = 0;
  logic [31:0] m_f, m_di, m_dp;
  logic m_da;
  vec_t tbl[24];
  fetch_stage_if bus();
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .imem(bus.master),
    .branch_en(branch_en), .branch_taken(branch_taken), .jump(jump), .rs_fwd(rs_fwd),
    .D_instr(D_instr), .D_pc(D_pc), .D_pc8(D_pc8), .D_adel(D_adel)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mix(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction
  always_comb bus.imem_rdata = ovr ? ovr_word : mix(bus.imem_addr);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic chk_all(input string nm, input logic [31:0] a, input logic [31:0] di, input logic [31:0] dp, input logic da);
    chk({nm, ".imem_addr"}, bus.imem_addr, a);
    chk({nm, ".D_instr"}, D_instr, di);
    chk({nm, ".D_pc"}, D_pc, dp);
    chk({nm, ".D_pc8"}, D_pc8, dp + 32'd8);
    chk({nm, ".D_adel"}, {31'b0, D_adel}, {31'b0, da});
  endtask
  task automatic do_reset(input string nm);
    stall = 0; flush = 0; branch_en = 0; branch_taken = 0; jump = JD; rs_fwd = 0;
    reset = 1;
    #1;
    chk_all(nm, 32'h3000, 32'h0, 32'h3000, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    m_f = 32'h3000; m_di = 0; m_dp = 32'h3000; m_da = 0;
  endtask
  task automatic apply(input vec_t v, input string nm);
    stall = v.st; flush = v.fl; branch_en = v.be; branch_taken = v.bt;
    jump = v.jp; rs_fwd = v.rs; ovr_word = v.rd; ovr = 1;
    @(posedge clk); #1;
    chk_all(nm, v.e_addr, v.e_instr, v.e_pc, v.e_adel);
  endtask
  task automatic model_edge(input logic st, input logic fl, input logic be, input logic bt,
                            input logic [1:0] jp, input logic [31:0] rs, input logic [31:0] rd);
    logic [31:0] nxt;
    logic bad;
    bad = (m_f % 4 != 0) || (m_f < 32'h3000) || (m_f > 32'h6FFC);
    if (jp == JR) nxt = rs;
    else if (jp == JI) nxt = {m_dp[31:28] + 4'((m_dp[27:0] + 28'd4) >> 28), m_di[25:0], 2'b00};
    else if (be && bt) nxt = m_dp + 32'd4 + 32'($signed(m_di[15:0]) * 4);
    else nxt = m_f + 32'd4;
    if (fl) begin
      m_di = 0; m_da = 0; m_dp = m_f;
      if (!st) m_f = nxt;
    end else if (!st) begin
      m_di = bad ? 32'h0 : rd; m_dp = m_f; m_da = bad; m_f = nxt;
    end
  endtask
  initial begin
    tbl[0]  = '{0,0,0,0,JD,32'h0,ORI,32'h3004,ORI,32'h3000,0};
    tbl[1]  = '{0,0,0,0,JD,32'h0,ORI,32'h3008,ORI,32'h3004,0};
    tbl[2]  = '{0,0,0,0,JD,32'h0,ORI,32'h300C,ORI,32'h3008,0};
    tbl[3]  = '{0,0,0,0,JD,32'h0,BEQ,32'h3010,BEQ,32'h300C,0};
    tbl[4]  = '{0,0,1,1,JD,32'h0,ORI,32'h3004,ORI,32'h3010,0};
    tbl[5]  = '{0,0,0,0,JD,32'h0,BEQ,32'h3008,BEQ,32'h3004,0};
    tbl[6]  = '{0,0,1,0,JD,32'h0,ORI,32'h300C,ORI,32'h3008,0};
    tbl[7]  = '{0,0,0,0,JR,32'h3000,ORI,32'h3000,ORI,32'h300C,0};
    tbl[8]  = '{0,0,0,0,JD,32'h0,JAL,32'h3004,JAL,32'h3000,0};
    tbl[9]  = '{0,0,0,0,JI,32'h0,ORI,32'h3040,ORI,32'h3004,0};
    tbl[10] = '{0,0,0,0,JR,32'h3100,ORI,32'h3100,ORI,32'h3040,0};
    tbl[11] = '{0,0,0,0,JD,32'h0,ORI,32'h3104,ORI,32'h3100,0};
    tbl[12] = '{0,0,0,0,JR,32'h3002,ORI,32'h3002,ORI,32'h3104,0};
    tbl[13] = '{0,0,0,0,JD,32'h0,ORI,32'h3006,32'h0,32'h3002,1};
    tbl[14] = '{0,0,0,0,JR,32'h7000,ORI,32'h7000,32'h0,32'h3006,1};
    tbl[15] = '{0,0,0,0,JD,32'h0,ORI,32'h7004,32'h0,32'h7000,1};
    tbl[16] = '{0,0,0,0,JR,32'h6FFC,ORI,32'h6FFC,32'h0,32'h7004,1};
    tbl[17] = '{0,0,0,0,JD,32'h0,ORI,32'h7000,ORI,32'h6FFC,0};
    tbl[18] = '{0,0,0,0,JR,32'h2FFC,ORI,32'h2FFC,32'h0,32'h7000,1};
    tbl[19] = '{0,0,0,0,JR,32'h3000,ORI,32'h3000,32'h0,32'h2FFC,1};
    tbl[20] = '{0,0,0,0,JD,32'h0,ORI,32'h3004,ORI,32'h3000,0};
    tbl[21] = '{0,0,0,0,JR,32'hFFFF_FFFC,ORI,32'hFFFF_FFFC,ORI,32'h3004,0};
    tbl[22] = '{0,0,0,0,JD,32'h0,ORI,32'h0,32'h0,32'hFFFF_FFFC,1};
    tbl[23] = '{0,0,0,0,JR,32'h3000,ORI,32'h3000,32'h0,32'h0,1};
    #2;
    do_reset("reset");
    for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("vec%0d", i));
    do_reset("reset_stall");
    apply('{0,0,0,0,JD,32'h0,BEQ,32'h3004,BEQ,32'h3000,0}, "stall_load");
    apply('{1,0,1,1,JD,32'h0,ORI,32'h3004,BEQ,32'h3000,0}, "stall_1");
    apply('{1,0,1,1,JD,32'h0,ORI,32'h3004,BEQ,32'h3000,0}, "stall_2");
    apply('{0,0,1,1,JD,32'h0,ORI,32'h2FF8,ORI,32'h3004,0}, "stall_release");
    apply('{0,0,0,0,JD,32'h0,ORI,32'h2FFC,32'h0,32'h2FF8,1}, "stall_after");
    do_reset("reset_flush");
    apply('{0,0,0,0,JD,32'h0,ORI,32'h3004,ORI,32'h3000,0}, "flush_load");
    apply('{1,1,0,0,JD,32'h0,ORI,32'h3004,32'h0,32'h3004,0}, "flush_stall");
    apply('{0,1,0,0,JD,32'h0,ORI,32'h3008,32'h0,32'h3004,0}, "flush_only");
    apply('{0,0,0,0,JR,32'h3001,ORI,32'h3001,ORI,32'h3008,0}, "jr_3001");
    apply('{0,1,0,0,JD,32'h0,ORI,32'h3005,32'h0,32'h3001,0}, "flush_bad");
    do_reset("reset_mid");
    for (int i = 0; i < 8; i++) apply('{0,0,0,0,JD,32'h0,ORI,32'h3004 + 32'(i) * 4,ORI,32'h3000 + 32'(i) * 4,0}, "run");
    #2;
    reset = 1;
    #1;
    chk_all("async_reset", 32'h3000, 32'h0, 32'h3000, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    ovr = 0;
    m_f = 32'h3000; m_di = 0; m_dp = 32'h3000; m_da = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 11) == 0);
      branch_en = 1'($urandom);
      branch_taken = 1'($urandom);
      r = $urandom_range(0, 5);
      jump = (r == 0) ? JR : (r == 1) ? JI : JD;
      rs_fwd = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
      model_edge(stall, flush, branch_en, branch_taken, jump, rs_fwd, mix(m_f));
      @(posedge clk); #1;
      chk_all($sformatf("rand%0d", i), m_f, m_di, m_dp, m_da);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
